// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types and defaults for the memory-stage stack engine.
//   - op_e        : the single memory operation selected in a cycle
//   - pop_kind_e  : which restore register a pop's read data is destined for
//   - DEF_*       : default widths and the empty-stack SP value
//   - op_is_push / op_is_pop : classify an op for the stack pointer
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int              DEF_DATA_W   = 16;
    localparam int              DEF_ADDR_W   = 12;
    localparam logic [11:0]     DEF_SP_RESET = 12'hFFF;

    typedef enum logic [3:0] {
        OP_IDLE,
        OP_PUSH_PC_HI,
        OP_PUSH_PC_LO,
        OP_PUSH_CCR,
        OP_PUSH_GEN,
        OP_POP_CCR,
        OP_POP_PC_LO,
        OP_POP_PC_HI,
        OP_POP_GEN,
        OP_LOAD,
        OP_STORE
    } op_e;

    typedef enum logic [1:0] {
        POP_NONE,
        POP_CCR,
        POP_PC_LO,
        POP_PC_HI
    } pop_kind_e;

    function automatic logic op_is_push(input op_e op);
        return (op inside {OP_PUSH_PC_HI, OP_PUSH_PC_LO, OP_PUSH_CCR, OP_PUSH_GEN});
    endfunction

    function automatic logic op_is_pop(input op_e op);
        return (op inside {OP_POP_CCR, OP_POP_PC_LO, OP_POP_PC_HI, OP_POP_GEN});
    endfunction

endpackage

// File: rtl/stack_pointer.sv
// -----------------------------------------------------------------------------
// stack_pointer
// Owns the stack pointer. The stack grows downward: a push writes at SP and
// then decrements (post-decrement), a pop reads at SP+1 and increments
// (pre-increment). Pushing at SP==0 or popping at the empty value sets a
// sticky error flag that only reset clears.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : push issued this cycle (mutually exclusive with i_pop)
//   i_pop        : pop issued this cycle
//   o_sp         : current SP (registered)
//   o_sp_up      : pop address for this cycle (SP+1, wrapping to 0 on underflow)
//   o_ovf, o_unf : sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module stack_pointer #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_sp_up,
    output logic              o_ovf,
    output logic              o_unf
);

    logic [ADDR_W-1:0] r_sp;
    logic              r_ovf;
    logic              r_unf;

    logic              w_at_empty;
    logic              w_at_bottom;
    logic [ADDR_W-1:0] w_sp_up;
    logic [ADDR_W-1:0] w_sp_down;

    always_comb begin
        w_at_empty  = (r_sp == SP_RESET);
        w_at_bottom = (r_sp == '0);
        // Popping an empty stack wraps to address 0 regardless of SP_RESET.
        w_sp_up     = w_at_empty ? '0 : (r_sp + ADDR_W'(1));
        // Pushing at 0 wraps naturally to all-ones.
        w_sp_down   = r_sp - ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= SP_RESET;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (i_push) begin
            r_sp <= w_sp_down;
            if (w_at_bottom) r_ovf <= 1'b1;
        end else if (i_pop) begin
            r_sp <= w_sp_up;
            if (w_at_empty) r_unf <= 1'b1;
        end
    end

    assign o_sp    = r_sp;
    assign o_sp_up = w_sp_up;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/stack_mem_unit.sv
// -----------------------------------------------------------------------------
// stack_mem_unit
// Memory-stage stack engine. Selects one memory access per cycle from the
// control-unit strobes, drives the data-memory address/data/enables, and
// reassembles PC (two 16-bit halves) and CCR values popped off the stack.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   stack, MemR, MemWR               : generic stack / memory strobes
//   pc_to_stack_1/2, ccr_to_stack    : interrupt/call push strobes
//   pop_ccr, pop_pc2, pop_pc1        : rti/ret pop strobes
//   alu_result, store_data, pc, ccr  : address and data sources
//   mem_rdata                        : synchronous read data (one cycle late)
//   mem_addr, mem_wdata, mem_we, mem_re : combinational memory interface
//   sp                               : current stack pointer
//   pc_restore(_valid)               : popped 32-bit PC + one-cycle pulse
//   ccr_restore(_valid)              : popped flags + one-cycle pulse
//   stack_ovf, stack_unf             : sticky stack error flags
// -----------------------------------------------------------------------------
module stack_mem_unit
    import stack_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stack,
    input  logic              MemR,
    input  logic              MemWR,
    input  logic              pc_to_stack_1,
    input  logic              pc_to_stack_2,
    input  logic              ccr_to_stack,
    input  logic              pop_ccr,
    input  logic              pop_pc2,
    input  logic              pop_pc1,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [31:0]       pc,
    input  logic [2:0]        ccr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] sp,
    output logic [31:0]       pc_restore,
    output logic              pc_restore_valid,
    output logic [2:0]        ccr_restore,
    output logic              ccr_restore_valid,
    output logic              stack_ovf,
    output logic              stack_unf
);

    op_e               w_op;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_sp_up;

    // Low PC half held from the pc_to_stack_1 cycle so both pushed halves
    // belong to the same PC even if the pipeline moves pc in between.
    logic [15:0]       r_pc_lo_latch;
    pop_kind_e         r_pop_kind;
    logic [15:0]       r_pc_lo_q;
    logic [31:0]       r_pc_restore;
    logic              r_pc_valid;
    logic [2:0]        r_ccr_restore;
    logic              r_ccr_valid;

    // ---------------------------------------------------------------- op select
    always_comb begin
        w_op = OP_IDLE;
        if      (ccr_to_stack)     w_op = OP_PUSH_CCR;
        else if (pc_to_stack_2)    w_op = OP_PUSH_PC_LO;
        else if (pc_to_stack_1)    w_op = OP_PUSH_PC_HI;
        else if (pop_ccr)          w_op = OP_POP_CCR;
        else if (pop_pc2)          w_op = OP_POP_PC_LO;
        else if (pop_pc1)          w_op = OP_POP_PC_HI;
        else if (stack && MemWR)   w_op = OP_PUSH_GEN;
        else if (stack && MemR)    w_op = OP_POP_GEN;
        else if (MemWR)            w_op = OP_STORE;
        else if (MemR)             w_op = OP_LOAD;
    end

    assign w_push = op_is_push(w_op);
    assign w_pop  = op_is_pop(w_op);

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_stack_pointer (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_sp    (w_sp),
        .o_sp_up (w_sp_up),
        .o_ovf   (stack_ovf),
        .o_unf   (stack_unf)
    );

    // ---------------------------------------------------- address / data muxes
    always_comb begin
        mem_addr  = w_sp;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (w_op)
            OP_PUSH_PC_HI: begin
                mem_wdata = DATA_W'(pc[31:16]);
                mem_we    = 1'b1;
            end
            OP_PUSH_PC_LO: begin
                mem_wdata = DATA_W'(r_pc_lo_latch);
                mem_we    = 1'b1;
            end
            OP_PUSH_CCR: begin
                mem_wdata = DATA_W'(ccr);
                mem_we    = 1'b1;
            end
            OP_PUSH_GEN: begin
                mem_wdata = store_data;
                mem_we    = 1'b1;
            end
            OP_POP_CCR, OP_POP_PC_LO, OP_POP_PC_HI, OP_POP_GEN: begin
                mem_addr  = w_sp_up;
                mem_re    = 1'b1;
            end
            OP_STORE: begin
                mem_addr  = alu_result;
                mem_wdata = store_data;
                mem_we    = 1'b1;
            end
            OP_LOAD: begin
                mem_addr  = alu_result;
                mem_re    = 1'b1;
            end
            default: ;
        endcase
        // No memory side effects while the engine is held in reset.
        if (rst) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    // ------------------------------------------------------------- PC latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_lo_latch <= '0;
        end else if (w_op == OP_PUSH_PC_HI) begin
            r_pc_lo_latch <= pc[15:0];
        end
    end

    // ------------------------------------------------------ pop tracker
    // Remembers what the pop issued this cycle was for, so the read data that
    // arrives next cycle can be steered to the right restore register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_kind <= POP_NONE;
        end else begin
            case (w_op)
                OP_POP_CCR:   r_pop_kind <= POP_CCR;
                OP_POP_PC_LO: r_pop_kind <= POP_PC_LO;
                OP_POP_PC_HI: r_pop_kind <= POP_PC_HI;
                default:      r_pop_kind <= POP_NONE;
            endcase
        end
    end

    // --------------------------------------------------- restore registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_lo_q     <= '0;
            r_pc_restore  <= '0;
            r_pc_valid    <= 1'b0;
            r_ccr_restore <= '0;
            r_ccr_valid   <= 1'b0;
        end else begin
            r_pc_valid  <= 1'b0;
            r_ccr_valid <= 1'b0;
            case (r_pop_kind)
                POP_PC_LO: r_pc_lo_q <= mem_rdata[15:0];
                POP_PC_HI: begin
                    r_pc_restore <= {mem_rdata[15:0], r_pc_lo_q};
                    r_pc_valid   <= 1'b1;
                end
                POP_CCR: begin
                    r_ccr_restore <= mem_rdata[2:0];
                    r_ccr_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sp                = w_sp;
    assign pc_restore        = r_pc_restore;
    assign pc_restore_valid  = r_pc_valid;
    assign ccr_restore       = r_ccr_restore;
    assign ccr_restore_valid = r_ccr_valid;

endmodule

// File: tb/tb_stack_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_mem_unit
// Directed bench for stack_mem_unit with a synchronous-read data memory.
// -----------------------------------------------------------------------------
module tb_stack_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stack, MemR, MemWR;
    logic        pc_to_stack_1, pc_to_stack_2, ccr_to_stack;
    logic        pop_ccr, pop_pc2, pop_pc1;
    logic [11:0] alu_result;
    logic [15:0] store_data;
    logic [31:0] pc;
    logic [2:0]  ccr;
    logic [15:0] mem_rdata;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [11:0] sp;
    logic [31:0] pc_restore;
    logic        pc_restore_valid;
    logic [2:0]  ccr_restore;
    logic        ccr_restore_valid;
    logic        stack_ovf, stack_unf;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    // Synchronous-read data memory: data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    stack_mem_unit dut (
        .clk               (clk),
        .rst               (rst),
        .stack             (stack),
        .MemR              (MemR),
        .MemWR             (MemWR),
        .pc_to_stack_1     (pc_to_stack_1),
        .pc_to_stack_2     (pc_to_stack_2),
        .ccr_to_stack      (ccr_to_stack),
        .pop_ccr           (pop_ccr),
        .pop_pc2           (pop_pc2),
        .pop_pc1           (pop_pc1),
        .alu_result        (alu_result),
        .store_data        (store_data),
        .pc                (pc),
        .ccr               (ccr),
        .mem_rdata         (mem_rdata),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_we            (mem_we),
        .mem_re            (mem_re),
        .sp                (sp),
        .pc_restore        (pc_restore),
        .pc_restore_valid  (pc_restore_valid),
        .ccr_restore       (ccr_restore),
        .ccr_restore_valid (ccr_restore_valid),
        .stack_ovf         (stack_ovf),
        .stack_unf         (stack_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        stack = 0; MemR = 0; MemWR = 0;
        pc_to_stack_1 = 0; pc_to_stack_2 = 0; ccr_to_stack = 0;
        pop_ccr = 0; pop_pc2 = 0; pop_pc1 = 0;
    endtask

    task automatic do_reset();
        clear_strobes();
        alu_result = '0; store_data = '0; pc = '0; ccr = '0;
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_strobes();
        alu_result = '0; store_data = '0; pc = 32'h1234_5678; ccr = '0;
        rst = 1;
        tick(); tick();
        pc_to_stack_1 = 1; MemR = 1;
        #1;
        total++; if (sp !== 12'hFFF) begin bad++; $display("FAIL reset_sp got=%h exp=fff", sp); end
        total++; if (pc_restore !== 32'h0) begin bad++; $display("FAIL reset_pc_restore got=%h exp=0", pc_restore); end
        total++; if (ccr_restore !== 3'h0) begin bad++; $display("FAIL reset_ccr_restore got=%h exp=0", ccr_restore); end
        total++; if ({pc_restore_valid, ccr_restore_valid} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {pc_restore_valid, ccr_restore_valid}); end
        total++; if ({stack_ovf, stack_unf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {stack_ovf, stack_unf}); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL reset_enables got=%b exp=00", {mem_we, mem_re}); end
        clear_strobes();
        rst = 0;
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_interrupt_rti();
        do_reset();
        pc = 32'h0001_2345; ccr = 3'b101;
        pc_to_stack_1 = 1; #1;
        $display("push pc_hi addr=%h data=%h we=%b", mem_addr, mem_wdata, mem_we);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 16'h0001}) begin bad++; $display("FAIL int_push1 got=%b/%h/%h exp=1/fff/0001", mem_we, mem_addr, mem_wdata); end
        tick(); pc_to_stack_1 = 0; pc_to_stack_2 = 1; #1;
        $display("push pc_lo addr=%h data=%h we=%b", mem_addr, mem_wdata, mem_we);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFE, 16'h2345}) begin bad++; $display("FAIL int_push2 got=%b/%h/%h exp=1/ffe/2345", mem_we, mem_addr, mem_wdata); end
        tick(); pc_to_stack_2 = 0; ccr_to_stack = 1; #1;
        $display("push ccr addr=%h data=%h we=%b", mem_addr, mem_wdata, mem_we);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFD, 16'h0005}) begin bad++; $display("FAIL int_push3 got=%b/%h/%h exp=1/ffd/0005", mem_we, mem_addr, mem_wdata); end
        tick(); ccr_to_stack = 0;
        total++; if (sp !== 12'hFFC) begin bad++; $display("FAIL int_sp_after_push got=%h exp=ffc", sp); end
        pop_ccr = 1; #1;
        $display("pop ccr addr=%h re=%b", mem_addr, mem_re);
        total++; if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 12'hFFD}) begin bad++; $display("FAIL rti_pop_ccr got=%b%b/%h exp=10/ffd", mem_re, mem_we, mem_addr); end
        tick(); pop_ccr = 0; pop_pc2 = 1; #1;
        total++; if (ccr_restore_valid !== 1'b0) begin bad++; $display("FAIL rti_ccr_valid_early got=%b exp=0", ccr_restore_valid); end
        total++; if (mem_addr !== 12'hFFE) begin bad++; $display("FAIL rti_pop_pc2_addr got=%h exp=ffe", mem_addr); end
        tick(); pop_pc2 = 0; pop_pc1 = 1; #1;
        total++; if ({ccr_restore_valid, ccr_restore} !== {1'b1, 3'd5}) begin bad++; $display("FAIL rti_ccr_restore got=%b/%h exp=1/5", ccr_restore_valid, ccr_restore); end
        total++; if (mem_addr !== 12'hFFF) begin bad++; $display("FAIL rti_pop_pc1_addr got=%h exp=fff", mem_addr); end
        tick(); pop_pc1 = 0;
        total++; if (sp !== 12'hFFF) begin bad++; $display("FAIL rti_sp_after_pop got=%h exp=fff", sp); end
        total++; if ({ccr_restore_valid, pc_restore_valid} !== 2'b00) begin bad++; $display("FAIL rti_valids_n1 got=%b exp=00", {ccr_restore_valid, pc_restore_valid}); end
        tick();
        $display("restore pc=%h valid=%b", pc_restore, pc_restore_valid);
        total++; if ({pc_restore_valid, pc_restore} !== {1'b1, 32'h0001_2345}) begin bad++; $display("FAIL rti_pc_restore got=%b/%h exp=1/00012345", pc_restore_valid, pc_restore); end
        tick();
        total++; if (pc_restore_valid !== 1'b0) begin bad++; $display("FAIL rti_pc_valid_width got=%b exp=0", pc_restore_valid); end
    endtask

    task automatic test_pc_change();
        do_reset();
        pc = 32'h0001_2345;
        pc_to_stack_1 = 1;
        tick(); pc_to_stack_1 = 0; pc = 32'hDEAD_BEEF; pc_to_stack_2 = 1; #1;
        $display("push pc_lo after pc change data=%h", mem_wdata);
        total++; if (mem_wdata !== 16'h2345) begin bad++; $display("FAIL pcchg_wdata got=%h exp=2345", mem_wdata); end
        tick(); pc_to_stack_2 = 0; pop_pc2 = 1;
        tick(); pop_pc2 = 0; pop_pc1 = 1;
        tick(); pop_pc1 = 0;
        tick();
        total++; if ({pc_restore_valid, pc_restore} !== {1'b1, 32'h0001_2345}) begin bad++; $display("FAIL pcchg_restore got=%b/%h exp=1/00012345", pc_restore_valid, pc_restore); end
    endtask

    task automatic test_generic_back_to_back();
        do_reset();
        stack = 1; MemWR = 1; store_data = 16'hA5A5; #1;
        $display("push gen addr=%h data=%h", mem_addr, mem_wdata);
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 16'hA5A5}) begin bad++; $display("FAIL gen_push got=%b/%h/%h exp=1/fff/a5a5", mem_we, mem_addr, mem_wdata); end
        tick(); MemWR = 0; MemR = 1; #1;
        total++; if (sp !== 12'hFFE) begin bad++; $display("FAIL gen_sp_push got=%h exp=ffe", sp); end
        total++; if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 12'hFFF}) begin bad++; $display("FAIL gen_pop got=%b%b/%h exp=10/fff", mem_re, mem_we, mem_addr); end
        tick(); clear_strobes();
        $display("pop gen rdata=%h sp=%h", mem_rdata, sp);
        total++; if (sp !== 12'hFFF) begin bad++; $display("FAIL gen_sp_pop got=%h exp=fff", sp); end
        total++; if (mem_rdata !== 16'hA5A5) begin bad++; $display("FAIL gen_rdata got=%h exp=a5a5", mem_rdata); end
        tick();
        total++; if ({pc_restore_valid, ccr_restore_valid} !== 2'b00) begin bad++; $display("FAIL gen_no_valid got=%b exp=00", {pc_restore_valid, ccr_restore_valid}); end
    endtask

    task automatic test_priority();
        do_reset();
        MemR = 1; alu_result = 12'h010; #1;
        $display("load addr=%h re=%b", mem_addr, mem_re);
        total++; if ({mem_re, mem_addr} !== {1'b1, 12'h010}) begin bad++; $display("FAIL load_addr got=%b/%h exp=1/010", mem_re, mem_addr); end
        tick(); MemR = 0; MemWR = 1; alu_result = 12'h123; store_data = 16'h7E7E; #1;
        total++; if (sp !== 12'hFFF) begin bad++; $display("FAIL load_sp got=%h exp=fff", sp); end
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h123, 16'h7E7E}) begin bad++; $display("FAIL store got=%b/%h/%h exp=1/123/7e7e", mem_we, mem_addr, mem_wdata); end
        tick(); stack = 1; store_data = 16'h0BAD;
        tick(); stack = 0; pop_pc2 = 1; #1;
        $display("pop_pc2+MemWR addr=%h we=%b re=%b", mem_addr, mem_we, mem_re);
        total++; if ({mem_we, mem_re, mem_addr} !== {1'b0, 1'b1, 12'hFFF}) begin bad++; $display("FAIL prio_pop_wins got=%b%b/%h exp=01/fff", mem_we, mem_re, mem_addr); end
        tick(); clear_strobes(); #1;
        total++; if ({mem_we, mem_re, mem_addr, mem_wdata} !== {2'b00, 12'hFFF, 16'h0}) begin bad++; $display("FAIL idle_outputs got=%b%b/%h/%h exp=00/fff/0000", mem_we, mem_re, mem_addr, mem_wdata); end
    endtask

    task automatic test_underflow();
        do_reset();
        stack = 1; MemR = 1; #1;
        $display("pop at empty addr=%h", mem_addr);
        total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL unf_addr got=%h exp=000", mem_addr); end
        tick(); clear_strobes();
        total++; if ({sp, stack_unf} !== {12'h000, 1'b1}) begin bad++; $display("FAIL unf_set got=%h/%b exp=000/1", sp, stack_unf); end
        tick(); tick();
        total++; if ({stack_unf, stack_ovf} !== 2'b10) begin bad++; $display("FAIL unf_sticky got=%b exp=10", {stack_unf, stack_ovf}); end
    endtask

    task automatic test_overflow();
        do_reset();
        stack = 1; MemWR = 1; store_data = 16'h1111;
        for (int i = 0; i < 4095; i++) tick();
        $display("after 4095 pushes sp=%h", sp);
        total++; if ({sp, stack_ovf} !== {12'h000, 1'b0}) begin bad++; $display("FAIL ovf_pre got=%h/%b exp=000/0", sp, stack_ovf); end
        total++; if ({mem_we, mem_addr} !== {1'b1, 12'h000}) begin bad++; $display("FAIL ovf_write got=%b/%h exp=1/000", mem_we, mem_addr); end
        tick(); clear_strobes();
        total++; if ({sp, stack_ovf, stack_unf} !== {12'hFFF, 1'b1, 1'b0}) begin bad++; $display("FAIL ovf_set got=%h/%b%b exp=fff/10", sp, stack_ovf, stack_unf); end
        tick();
        total++; if (stack_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", stack_ovf); end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        pc = 32'hCAFE_F00D;
        pc_to_stack_1 = 1;
        tick(); pc_to_stack_1 = 0; pc_to_stack_2 = 1;
        tick(); pc_to_stack_2 = 0; pop_pc2 = 1;
        tick(); pop_pc2 = 0; pop_pc1 = 1;
        tick(); pop_pc1 = 0;
        rst = 1; #1;
        $display("reset mid-capture sp=%h", sp);
        total++; if (sp !== 12'hFFF) begin bad++; $display("FAIL midrst_sp got=%h exp=fff", sp); end
        total++; if ({pc_restore, pc_restore_valid} !== {32'h0, 1'b0}) begin bad++; $display("FAIL midrst_pc got=%h/%b exp=0/0", pc_restore, pc_restore_valid); end
        total++; if ({stack_ovf, stack_unf, mem_we, mem_re} !== 4'b0000) begin bad++; $display("FAIL midrst_misc got=%b exp=0000", {stack_ovf, stack_unf, mem_we, mem_re}); end
        tick(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc_restore_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_pulse got=%b exp=0 cycle=%0d", pc_restore_valid, i); end
        end
    endtask

    initial begin
        rst = 1;
        clear_strobes();
        test_reset();
        test_interrupt_rti();
        test_pc_change();
        test_generic_back_to_back();
        test_priority();
        test_underflow();
        test_overflow();
        test_reset_mid_capture();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
